iter_mul_unit: RTL and testbench
================================

ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 kill_mul_i  input  1  flush; aborts any operation in flight.
REQ-005 request_i  input  1  start a multiplication; sampled only in IDLE.
REQ-006 int_32_i  input  1  word operation (MULW); 32-bit operands and result.
REQ-007 func_i  input  2  00 MUL (low 64), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high); ignored when int_32_i=1.
REQ-008 src1_i  input  64  multiplicand (rs1).
REQ-009 src2_i  input  64  multiplier (rs2).
REQ-010 result_o  output  64  product; valid only while done_tick_o=1, 0 otherwise.
REQ-011 stall_o  output  1  operation in flight; pipeline holds while high.
REQ-012 done_tick_o  output  1  one-cycle pulse: result_o valid.

Function
REQ-013 The FSM SHALL have states IDLE, OP, DONE; encodings outside these SHALL go to IDLE.
REQ-014 IDLE: request_i=1 and kill_mul_i=0 SHALL accept (stall_o=1 same cycle) and go to OP; otherwise stay IDLE, stall_o=0.
REQ-015 On accept, operands, int_32_i and func_i SHALL be latched; inputs are not re-sampled until the next accept.
REQ-016 Operand signedness: src1 signed for MULH/MULHSU; src2 signed for MULH only; all unsigned for MUL and int_32_i=1.
REQ-017 Signed negative operands SHALL be replaced by their two's-complement magnitude; result sign latched as neg1 XOR neg2.
REQ-018 int_32_i=1: only src[31:0] SHALL be used (upper bits ignored), zero-extended.
REQ-019 Iteration count N SHALL be 64 (int_32_i=0) or 32 (int_32_i=1), held in a down-counter loaded at accept.
REQ-020 Each OP cycle SHALL examine the multiplier LSB, add the shifted multiplicand into a 128-bit accumulator if set, shift multiplier right by 1, decrement counter.
REQ-021 After the N-th OP cycle the FSM SHALL go to DONE; stall_o=1 throughout OP.
REQ-022 DONE: done_tick_o=1, stall_o=0, next state IDLE; exactly one DONE cycle per accepted, unkilled request.
REQ-023 Latency: accept in cycle t -> done_tick_o in cycle t+N+1 (t+65 or t+33); stall_o high cycles t..t+N.
REQ-024 If result sign is negative, the full 128-bit magnitude SHALL be two's-complement negated before selection.
REQ-025 result_o: MUL = prod[63:0]; MULH/MULHSU/MULHU = prod[127:64]; int_32_i=1 = prod[31:0] sign-extended from bit 31.
REQ-026 result_o and done_tick_o SHALL be 0 in every non-DONE cycle.
REQ-027 kill_mul_i=1 in OP or DONE SHALL force next state IDLE, stall_o=0 and done_tick_o=0 in that cycle; no result is produced.
REQ-028 kill_mul_i and request_i both high in IDLE: request SHALL be ignored.
REQ-029 request_i while in OP/DONE SHALL be ignored (no queueing); a new request is accepted in the first IDLE cycle.
REQ-030 Zero operand SHALL still take full latency N; no early termination.

Reset
REQ-031 rstn_i low SHALL immediately force state IDLE, accumulator, operand registers and counter to 0.
REQ-032 During and after reset until accept: stall_o=0, done_tick_o=0, result_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon it; no done_tick_o follows release.

Verification
REQ-034 MUL, src1=3, src2=7 at cycle t -> done_tick_o at t+65, result_o=21; stall_o high t..t+64.
REQ-035 MULH, src1=src2=0xFFFFFFFFFFFFFFFF -> result_o=0; same with MUL -> result_o=1.
REQ-036 MULHU, src1=src2=0xFFFFFFFFFFFFFFFF -> result_o=0xFFFFFFFFFFFFFFFE; MULHSU, src1=0xFFFFFFFFFFFFFFFE, src2=3 -> result_o=0xFFFFFFFFFFFFFFFF.
REQ-037 int_32_i=1, src1=0xABCD00007FFFFFFF, src2=2 at t -> done_tick_o at t+33, result_o=0xFFFFFFFFFFFFFFFE.
REQ-038 MUL accepted at t, kill_mul_i pulsed at t+10 -> IDLE at t+11, no done_tick_o; new request at t+11 completes at t+76.
REQ-039 rstn_i asserted at t+20 of an active op, released at t+25 -> all outputs 0, no done_tick_o until a new request.

Source files
------------

// File: rtl/iter_mul_unit.sv
// Iterative 64-bit shift-and-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// One multiplier bit is consumed per cycle: 64 cycles for 64-bit ops, 32 for MULW.
// Ports:
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   kill_mul_i            flush; abandons any operation in flight
//   request_i             start request, sampled only in idle
//   int_32_i, func_i      operation select (word op overrides func_i)
//   src1_i, src2_i        operands (rs1, rs2)
//   result_o              product, non-zero only while done_tick_o is high
//   stall_o               high from accept through the last iteration
//   done_tick_o           one-cycle pulse marking result_o valid
module iter_mul_unit (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        kill_mul_i,
  input  logic        request_i,
  input  logic        int_32_i,
  input  logic [1:0]  func_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  output logic [63:0] result_o,
  output logic        stall_o,
  output logic        done_tick_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOp   = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e r_state, w_state_next;

  logic [127:0] r_mcand;   // multiplicand, shifted left each iteration
  logic [63:0]  r_mplier;  // multiplier, shifted right each iteration
  logic [127:0] r_acc;
  logic [6:0]   r_cnt;
  logic         r_neg;
  logic         r_int32;
  logic [1:0]   r_func;

  // Operand preparation: convert signed negatives to magnitudes.
  logic        w_s1_signed, w_s2_signed;
  logic [63:0] w_op1, w_op2, w_mag1, w_mag2;
  logic        w_neg1, w_neg2, w_accept;

  assign w_s1_signed = ~int_32_i & ((func_i == 2'b01) | (func_i == 2'b10));
  assign w_s2_signed = ~int_32_i & (func_i == 2'b01);
  assign w_op1       = int_32_i ? {32'b0, src1_i[31:0]} : src1_i;
  assign w_op2       = int_32_i ? {32'b0, src2_i[31:0]} : src2_i;
  assign w_neg1      = w_s1_signed & w_op1[63];
  assign w_neg2      = w_s2_signed & w_op2[63];
  assign w_mag1      = w_neg1 ? (~w_op1 + 64'd1) : w_op1;
  assign w_mag2      = w_neg2 ? (~w_op2 + 64'd1) : w_op2;
  assign w_accept    = (r_state == StIdle) & request_i & ~kill_mul_i;

  // Result formation from the unsigned magnitude product.
  logic [127:0] w_prod;
  logic [63:0]  w_result;

  assign w_prod = r_neg ? (~r_acc + 128'd1) : r_acc;

  always_comb begin
    w_result = w_prod[127:64];
    if (r_int32) begin
      w_result = {{32{w_prod[31]}}, w_prod[31:0]};
    end else if (r_func == 2'b00) begin
      w_result = w_prod[63:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    stall_o      = 1'b0;
    done_tick_o  = 1'b0;
    result_o     = 64'd0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          stall_o      = 1'b1;
          w_state_next = StOp;
        end
      end
      StOp: begin
        if (kill_mul_i) begin
          w_state_next = StIdle;
        end else begin
          stall_o = 1'b1;
          // Counter still holds 1 during the last iteration.
          if (r_cnt == 7'd1) w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
        if (!kill_mul_i) begin
          done_tick_o = 1'b1;
          result_o    = w_result;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_int32  <= 1'b0;
      r_func   <= 2'b00;
    end else if (w_accept) begin
      r_mcand  <= {64'd0, w_mag1};
      r_mplier <= w_mag2;
      r_acc    <= '0;
      r_cnt    <= int_32_i ? 7'd32 : 7'd64;
      r_neg    <= w_neg1 ^ w_neg2;
      r_int32  <= int_32_i;
      r_func   <= func_i;
    end else if ((r_state == StOp) && !kill_mul_i) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= {r_mcand[126:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[63:1]};
      r_cnt    <= r_cnt - 7'd1;
    end
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
module tb_iter_mul_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        kill_mul_i;
  logic        request_i;
  logic        int_32_i;
  logic [1:0]  func_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic [63:0] result_o;
  logic        stall_o;
  logic        done_tick_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  iter_mul_unit dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .kill_mul_i  (kill_mul_i),
    .request_i   (request_i),
    .int_32_i    (int_32_i),
    .func_i      (func_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .result_o    (result_o),
    .stall_o     (stall_o),
    .done_tick_o (done_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width product of sign/zero-extended operands.
  function automatic logic [63:0] model(input logic [1:0] f, input logic i32,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    if (i32) begin
      p = {96'd0, a[31:0]} * {96'd0, b[31:0]};
      return {{32{p[31]}}, p[31:0]};
    end
    ea = (f == 2'b01 || f == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (f == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Drive a request in the current cycle (called just after a negedge).
  task automatic issue(input logic [1:0] f, input logic i32, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
    func_i    = f;
    int_32_i  = i32;
    src1_i    = a;
    src2_i    = b;
    request_i = 1'b1;
    #1;
    chk("accept_stall", {63'd0, stall_o}, 64'd1);
    exp_q.push_back(exp);
  endtask

  task automatic wait_done(input int n, input string tag);
    int          lat = -1;
    bit          stall_bad = 0;
    bit          extra_bad = 0;
    logic [63:0] got = '0;
    logic [63:0] exp;
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk_i);
      request_i = 1'b0;
      #1;
      if (done_tick_o === 1'b1) begin
        if (lat < 0) begin
          lat = k;
          got = result_o;
        end else begin
          extra_bad = 1;
        end
      end else if (result_o !== 64'd0) begin
        extra_bad = 1;
      end
      if (stall_o !== (k <= n)) stall_bad = 1;
    end
    exp = exp_q.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(n + 1));
    chk({tag, "_result"}, got, exp);
    chk({tag, "_stall_profile"}, {62'd0, extra_bad, stall_bad}, 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    logic [1:0]  f;
    bit          bad;

    rstn_i     = 1'b0;
    kill_mul_i = 1'b0;
    request_i  = 1'b0;
    int_32_i   = 1'b0;
    func_i     = 2'b00;
    src1_i     = '0;
    src2_i     = '0;
    #1;
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_done", {63'd0, done_tick_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    issue(2'b00, 1'b0, 64'd3, 64'd7, 64'd21);
    wait_done(64, "mul_3x7");
    issue(2'b01, 1'b0, '1, '1, 64'd0);
    wait_done(64, "mulh_m1");
    issue(2'b00, 1'b0, '1, '1, 64'd1);
    wait_done(64, "mul_m1");
    issue(2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(64, "mulhu_max");
    issue(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, '1);
    wait_done(64, "mulhsu_neg");
    issue(2'b01, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(32, "mulw");
    issue(2'b01, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 64'd0);
    wait_done(64, "zero_op");
    issue(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000);
    wait_done(64, "mulh_minint");

    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      f = 2'(i);
      issue(f, 1'b0, a, b, model(f, 1'b0, a, b));
      wait_done(64, "rand64");
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    issue(2'b10, 1'b1, a, b, model(2'b10, 1'b1, a, b));
    wait_done(32, "rand32");

    // Kill at t+10, new request at t+11.
    issue(2'b00, 1'b0, 64'd5, 64'd9, 64'd45);
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      request_i = 1'b1;  // ignored while busy
      src1_i    = 64'd100;
      if (k == 10) kill_mul_i = 1'b1;
      #1;
      if (k < 10 && (stall_o !== 1'b1 || done_tick_o !== 1'b0)) bad = 1;
    end
    chk("busy_stall", {63'd0, bad}, 64'd0);
    chk("kill_stall", {63'd0, stall_o}, 64'd0);
    chk("kill_done", {63'd0, done_tick_o}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk_i);
    kill_mul_i = 1'b0;
    issue(2'b00, 1'b0, 64'd6, 64'd11, 64'd66);
    wait_done(64, "after_kill");

    // Reset at t+20, released at t+25.
    issue(2'b11, 1'b0, 64'd12, 64'd13, 64'd0);
    repeat (20) begin
      @(negedge clk_i);
      request_i = 1'b0;
    end
    rstn_i = 1'b0;
    #1;
    chk("midrst_stall", {63'd0, stall_o}, 64'd0);
    chk("midrst_done", {63'd0, done_tick_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    void'(exp_q.pop_front());
    repeat (5) @(negedge clk_i);
    rstn_i = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk_i);
      #1;
      if (stall_o !== 1'b0 || done_tick_o !== 1'b0 || result_o !== 64'd0) bad = 1;
    end
    chk("post_reset_quiet", {63'd0, bad}, 64'd0);
    issue(2'b00, 1'b0, 64'd4, 64'd4, 64'd16);
    wait_done(64, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
